// File: rtl/amber128_uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, and a 1-entry valid/ready
// holding buffer with frame-error and overrun pulses.
module amber128_uart_rx #(
   parameter int unsigned CLOCK_FREQ_HZ = 27_000_000,
   parameter int unsigned BAUD_RATE     = 115_200
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int unsigned CLKS_PER_BIT = (CLOCK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("amber128_uart_rx: CLKS_PER_BIT must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            deliver;
   logic            stop_err;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      deliver  = 1'b0;
      stop_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d    = '0;
               deliver  = rx_s;
               stop_err = !rx_s;
               state_d  = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            // Only one frame error per low period: wait out the line before rearming.
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= stop_err;
         overrun_o   <= deliver && valid_o && !ready_i;
         // A consume and a load in the same cycle keep valid_o high with the new byte.
         if (deliver && (!valid_o || ready_i)) begin
            data_o  <= shreg_q;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_amber128_uart_rx.sv
// Bench for amber128_uart_rx: behavioural 8N1 line driver, frame-level reference model
// compared every cycle, plus directed literal checks.
module tb_amber128_uart_rx;

   localparam int CPB     = 234;
   localparam int HALF    = 117;
   localparam int LATENCY = 2 + HALF + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx = 1'b1;
   logic       rdy = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;

   always #5 clk = ~clk;

   amber128_uart_rx #(
      .CLOCK_FREQ_HZ(27_000_000),
      .BAUD_RATE    (115_200)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .rx_i       (rx),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (rdy),
      .frame_err_o(frame_err_o),
      .overrun_o  (overrun_o)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   int         last_vrise = 0;
   int         start_edge = 0;
   logic       prev_v = 1'b0;
   bit         chk_en = 1'b0;
   bit         rand_rdy = 1'b0;
   logic [7:0] rxq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference model: frame timing derived from the edge at which the synchronized line is
   // first seen low; bit k is decided HALF + k*CPB edges later.
   int         mn = 0;
   int         m_mode = 0;
   int         m_t0 = 0;
   int         off;
   int         k;
   logic       s1 = 1'b1, s2 = 1'b1, rs;
   logic [7:0] m_byte = '0;
   logic [7:0] e_data = '0;
   logic       e_valid = 1'b0, e_ferr = 1'b0, e_ovr = 1'b0;
   logic       ev_del, ev_err;

   initial begin
      forever begin
         @(posedge clk);
         mn++;
         if (!rst_n) begin
            s1 = 1'b1; s2 = 1'b1; m_mode = 0; m_byte = '0;
            e_data = '0; e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
         end else begin
            rs = s2; s2 = s1; s1 = rx;
            ev_del = 1'b0;
            ev_err = 1'b0;
            if (m_mode == 0) begin
               if (!rs) begin m_mode = 1; m_t0 = mn; end
            end else if (m_mode == 1) begin
               off = mn - m_t0;
               if (off >= HALF && ((off - HALF) % CPB) == 0) begin
                  k = (off - HALF) / CPB;
                  if (k == 0) begin
                     if (rs) m_mode = 0;
                  end else if (k <= 8) begin
                     m_byte[k-1] = rs;
                  end else begin
                     ev_del = rs;
                     ev_err = !rs;
                     m_mode = rs ? 0 : 2;
                  end
               end
            end else begin
               if (rs) m_mode = 0;
            end
            e_ferr = ev_err;
            e_ovr  = 1'b0;
            if (ev_del) begin
               if (!e_valid || rdy) begin e_data = m_byte; e_valid = 1'b1; end
               else e_ovr = 1'b1;
            end else if (e_valid && rdy) begin
               e_valid = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (!rst_n) begin
               check("valid_o", int'(valid_o), 0);
               check("data_o", int'(data_o), 0);
               check("frame_err_o", int'(frame_err_o), 0);
               check("overrun_o", int'(overrun_o), 0);
            end else begin
               check("valid_o", int'(valid_o), int'(e_valid));
               check("data_o", int'(data_o), int'(e_data));
               check("frame_err_o", int'(frame_err_o), int'(e_ferr));
               check("overrun_o", int'(overrun_o), int'(e_ovr));
               if (valid_o && rdy) rxq.push_back(data_o);
               if (frame_err_o) ferr_cnt++;
               if (overrun_o) ovr_cnt++;
               if (valid_o && !prev_v) last_vrise = cyc;
            end
            prev_v = valid_o;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         if (i == 0) start_edge = cyc + 1;
         repeat (cpb) tick();
      end
   endtask

   task automatic check_rxq(input string tag, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] exp_b[3];
      exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
      check({tag, "_count"}, rxq.size(), n);
      for (int i = 0; i < n && i < rxq.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), int'(rxq[i]), int'(exp_b[i]));
   endtask

   int f0, o0, cpbs[3];
   logic [9:0] fr6;

   initial begin
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      check("reset_valid", int'(valid_o), 0);
      check("reset_data", int'(data_o), 0);

      // 1: single byte, latency and handshake
      idle(20);
      send_byte(8'hA5, CPB, 1'b1);
      check("t1_latency", last_vrise - start_edge, LATENCY);
      check("t1_valid", int'(valid_o), 1);
      check("t1_data", int'(data_o), 8'hA5);
      rdy = 1'b1;
      tick();
      check("t1_valid_drop", int'(valid_o), 0);

      // 2: back-to-back frames at nominal and +-2% skewed baud
      cpbs[0] = CPB; cpbs[1] = 239; cpbs[2] = 229;
      for (int j = 0; j < 3; j++) begin
         rxq.delete(); f0 = ferr_cnt; o0 = ovr_cnt;
         rdy = 1'b1;
         send_byte(8'h00, cpbs[j], 1'b1);
         send_byte(8'hFF, cpbs[j], 1'b1);
         send_byte(8'h55, cpbs[j], 1'b1);
         idle(300);
         check_rxq($sformatf("t2_cpb%0d", cpbs[j]), 3, 8'h00, 8'hFF, 8'h55);
         check("t2_ferr", ferr_cnt - f0, 0);
         check("t2_ovr", ovr_cnt - o0, 0);
      end

      // 3: short low glitch is rejected
      rxq.delete(); f0 = ferr_cnt;
      idle(100);
      rx = 1'b0;
      repeat (50) tick();
      idle(300);
      send_byte(8'h3C, CPB, 1'b1);
      idle(300);
      check_rxq("t3", 1, 8'h3C, 8'h00, 8'h00);
      check("t3_ferr", ferr_cnt - f0, 0);

      // 4: stop bit low, then line held low
      rxq.delete(); f0 = ferr_cnt;
      send_byte(8'h81, CPB, 1'b0);
      rx = 1'b0;
      repeat (5000) tick();
      check("t4_ferr_once", ferr_cnt - f0, 1);
      check("t4_valid", int'(valid_o), 0);
      idle(300);
      send_byte(8'h42, CPB, 1'b1);
      idle(300);
      check_rxq("t4", 1, 8'h42, 8'h00, 8'h00);
      check("t4_ferr_after", ferr_cnt - f0, 1);

      // 5: overrun while the buffer is held
      rxq.delete(); o0 = ovr_cnt;
      rdy = 1'b0;
      send_byte(8'h11, CPB, 1'b1);
      send_byte(8'h22, CPB, 1'b1);
      idle(300);
      check("t5_valid", int'(valid_o), 1);
      check("t5_data", int'(data_o), 8'h11);
      check("t5_ovr_once", ovr_cnt - o0, 1);
      rdy = 1'b1;
      tick();
      check("t5_valid_drop", int'(valid_o), 0);
      check_rxq("t5", 1, 8'h11, 8'h00, 8'h00);

      // 6: reset during data bit 4 with a byte pending
      rdy = 1'b0;
      send_byte(8'h33, CPB, 1'b1);
      idle(50);
      fr6 = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rx = fr6[i];
         repeat (CPB) tick();
      end
      rx = fr6[5];
      repeat (HALF) tick();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", int'(valid_o), 0);
      check("t6_rst_data", int'(data_o), 0);
      check("t6_rst_ferr", int'(frame_err_o), 0);
      check("t6_rst_ovr", int'(overrun_o), 0);
      rx = 1'b1;
      repeat (10) tick();
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      rxq.delete(); f0 = ferr_cnt; o0 = ovr_cnt;
      rdy = 1'b1;
      idle(300);
      send_byte(8'h7E, CPB, 1'b1);
      idle(300);
      check_rxq("t6", 1, 8'h7E, 8'h00, 8'h00);
      check("t6_ferr", ferr_cnt - f0, 0);
      check("t6_ovr", ovr_cnt - o0, 0);

      // random bytes, gaps, baud and consumer stalls; checked by the model only
      rand_rdy = 1'b1;
      repeat (6) begin
         send_byte(8'($urandom_range(0, 255)), $urandom_range(230, 238), 1'b1);
         idle($urandom_range(0, 400));
      end
      rand_rdy = 1'b0;
      rdy = 1'b1;
      idle(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
